// File: rtl/sb_spi_pkg.sv
// Shared definitions for the SB_SPI system-bus host: register map, status bits, FSM states.
package sb_spi_pkg;

  localparam logic [3:0] OFF_CR0  = 4'h8;
  localparam logic [3:0] OFF_CR1  = 4'h9;
  localparam logic [3:0] OFF_CR2  = 4'hA;
  localparam logic [3:0] OFF_BR   = 4'hB;
  localparam logic [3:0] OFF_SR   = 4'hC;
  localparam logic [3:0] OFF_TXDR = 4'hD;
  localparam logic [3:0] OFF_RXDR = 4'hE;
  localparam logic [3:0] OFF_CSR  = 4'hF;

  localparam int SR_TIP  = 7;
  localparam int SR_TRDY = 4;
  localparam int SR_RRDY = 3;

  typedef enum logic [3:0] {
    ST_CFG0, ST_CFG1, ST_CFG2, ST_CFGBR, ST_IDLE, ST_CS_ON, ST_POLL_TRDY,
    ST_WR_TX, ST_POLL_RRDY, ST_RD_RX, ST_EMIT, ST_POLL_TIP, ST_CS_OFF
  } state_e;

  function automatic logic [7:0] cs_onehot(input logic [1:0] cs);
    return 8'h01 << cs;
  endfunction

endpackage

// File: rtl/sb_bus_initiator.sv
// Single-access engine for the SB_SPI register port: registered strobe/address/data,
// completion on the first sampled ack, and a strobe-length watchdog.
module sb_bus_initiator #(
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_i,
  input  logic       we_i,
  input  logic [7:0] adr_i,
  input  logic [7:0] wdat_i,
  output logic       stb_o,
  output logic       rw_o,
  output logic [7:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_r_i,
  input  logic       ack_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic          stb_q, rw_q;
  logic [7:0]    adr_q, dat_q;
  logic [CW-1:0] cnt_q;

  // Completion is visible in the ack cycle so the caller can present the next
  // request during the mandatory low cycle that follows.
  assign done_o    = stb_q & ack_i;
  assign timeout_o = stb_q & ~ack_i & (cnt_q == CW'(TIMEOUT - 1));
  assign rdata_o   = dat_r_i;

  assign stb_o = stb_q;
  assign rw_o  = rw_q;
  assign adr_o = adr_q;
  assign dat_o = dat_q;

  // A request is only taken while the strobe is low, which guarantees the idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_q <= 1'b0;
      rw_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      cnt_q <= '0;
    end else if (stb_q) begin
      if (done_o || timeout_o) stb_q <= 1'b0;
      else                     cnt_q <= cnt_q + CW'(1);
    end else if (req_i) begin
      stb_q <= 1'b1;
      rw_q  <= we_i;
      adr_q <= adr_i;
      dat_q <= wdat_i;
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/sb_spi_host.sv
// Byte-stream SPI master on top of the iCE40 SB_SPI hard IP: configures the IP,
// frames transfers with chip select and moves bytes by status polling.
module sb_spi_host
  import sb_spi_pkg::*;
#(
  parameter logic [3:0] BUS_ADDR74 = 4'b0000,
  parameter logic [7:0] CR0_VAL    = 8'h00,
  parameter logic [7:0] CR1_VAL    = 8'h80,
  parameter logic [7:0] CR2_VAL    = 8'hC0,
  parameter logic [7:0] BR_VAL     = 8'h05,
  parameter int         TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic [1:0] tx_cs,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       err,
  output logic       sb_rw,
  output logic       sb_stb,
  output logic [7:0] sb_adr,
  output logic [7:0] sb_dat_w,
  input  logic [7:0] sb_dat_r,
  input  logic       sb_ack
);

  state_e     state_q, state_d;
  logic [1:0] cs_q, cs_d;
  logic       last_q, last_d;
  logic       tx_ready_q, tx_ready_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       err_q, err_d;

  logic       req, we;
  logic [3:0] off;
  logic [7:0] wdat;
  logic       done, tmo;
  logic [7:0] rdata;

  sb_bus_initiator #(.TIMEOUT(TIMEOUT)) u_bus (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .we_i      (we),
    .adr_i     ({BUS_ADDR74, off}),
    .wdat_i    (wdat),
    .stb_o     (sb_stb),
    .rw_o      (sb_rw),
    .adr_o     (sb_adr),
    .dat_o     (sb_dat_w),
    .dat_r_i   (sb_dat_r),
    .ack_i     (sb_ack),
    .done_o    (done),
    .rdata_o   (rdata),
    .timeout_o (tmo)
  );

  always_comb begin
    state_d    = state_q;
    cs_d       = cs_q;
    last_d     = last_q;
    tx_ready_d = tx_ready_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    err_d      = err_q;
    req        = 1'b0;
    we         = 1'b0;
    off        = OFF_SR;
    wdat       = 8'h00;
    unique case (state_q)
      ST_CFG0: begin
        req = 1'b1; we = 1'b1; off = OFF_CR0; wdat = CR0_VAL;
        if (done) state_d = ST_CFG1;
      end
      ST_CFG1: begin
        req = 1'b1; we = 1'b1; off = OFF_CR1; wdat = CR1_VAL;
        if (done) state_d = ST_CFG2;
      end
      ST_CFG2: begin
        req = 1'b1; we = 1'b1; off = OFF_CR2; wdat = CR2_VAL;
        if (done) state_d = ST_CFGBR;
      end
      ST_CFGBR: begin
        req = 1'b1; we = 1'b1; off = OFF_BR; wdat = BR_VAL;
        if (done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (tx_valid) begin
          cs_d    = tx_cs;
          state_d = ST_CS_ON;
        end
      end
      ST_CS_ON: begin
        req = 1'b1; we = 1'b1; off = OFF_CSR; wdat = cs_onehot(cs_q);
        if (done) state_d = ST_POLL_TRDY;
      end
      ST_POLL_TRDY: begin
        req = 1'b1;
        if (done && rdata[SR_TRDY]) begin
          state_d    = ST_WR_TX;
          tx_ready_d = 1'b1;
        end
      end
      ST_WR_TX: begin
        // The initiator is idle here, so the write is launched in the handshake cycle.
        if (tx_ready_q && tx_valid) begin
          req = 1'b1; we = 1'b1; off = OFF_TXDR; wdat = tx_data;
          tx_ready_d = 1'b0;
          last_d     = tx_last;
        end
        if (done) state_d = ST_POLL_RRDY;
      end
      ST_POLL_RRDY: begin
        req = 1'b1;
        if (done && rdata[SR_RRDY]) state_d = ST_RD_RX;
      end
      ST_RD_RX: begin
        req = 1'b1; off = OFF_RXDR;
        if (done) begin
          rx_data_d  = rdata;
          rx_valid_d = 1'b1;
          state_d    = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (rx_valid_q) begin
          if (rx_ready) begin
            rx_valid_d = 1'b0;
            if (last_q)        state_d = ST_POLL_TIP;
            else if (tx_valid) state_d = ST_POLL_TRDY;
          end
        end else if (tx_valid) begin
          state_d = ST_POLL_TRDY;
        end
      end
      ST_POLL_TIP: begin
        req = 1'b1;
        if (done && !rdata[SR_TIP]) state_d = ST_CS_OFF;
      end
      ST_CS_OFF: begin
        req = 1'b1; we = 1'b1; off = OFF_CSR; wdat = 8'h00;
        if (done) state_d = ST_IDLE;
      end
      default: state_d = ST_CFG0;
    endcase
    // A hung access abandons the frame; chip-select state on the IP is then unknown.
    if (tmo) begin
      state_d    = ST_IDLE;
      err_d      = 1'b1;
      tx_ready_d = 1'b0;
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CFG0;
      cs_q       <= '0;
      last_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cs_q       <= cs_d;
      last_q     <= last_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      err_q      <= err_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign err      = err_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sb_spi_host.sv
// Scoreboard bench for sb_spi_host: a responder models the SB_SPI register port,
// expected bus accesses and RX bytes are queued at stimulus and drained at the end.
module tb_sb_spi_host;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0, tx_last = 1'b0, rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] tx_cs = 2'd0;
  logic       tx_ready, rx_valid, busy, err, sb_rw, sb_stb;
  logic [7:0] rx_data, sb_adr, sb_dat_w;
  logic [7:0] sb_dat_r = 8'h00;
  logic       sb_ack = 1'b0;

  int n_chk = 0, n_fail = 0;

  logic [16:0] exp_bus[$], obs_bus[$];
  logic [7:0]  exp_rx[$], obs_rx[$], sr_q[$], rx_q[$];
  bit          noack = 1'b0, resp_prev = 1'b0;
  int          txdr_cnt = 0, csr_cnt = 0, tx_hi_cnt = 0;

  bit          mon_prev = 1'b0, have_fall = 1'b0, unstable = 1'b0;
  int          hi_run = 0, lo_run = 0, max_hi = 0, min_gap = 999;
  logic [16:0] stb_ref = '0;

  sb_spi_host #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_last(tx_last), .tx_cs(tx_cs), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_data(rx_data), .busy(busy), .err(err),
    .sb_rw(sb_rw), .sb_stb(sb_stb), .sb_adr(sb_adr), .sb_dat_w(sb_dat_w),
    .sb_dat_r(sb_dat_r), .sb_ack(sb_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] wr(input logic [7:0] a, input logic [7:0] d);
    return {1'b1, a, d};
  endfunction
  function automatic logic [16:0] rd(input logic [7:0] a);
    return {1'b0, a, 8'h00};
  endfunction

  // Register-port responder: acks one cycle after the strobe is first seen.
  always @(negedge clk) begin
    if (sb_stb && resp_prev && !sb_ack && !noack) begin
      sb_ack = 1'b1;
      sb_dat_r = 8'h00;
      if (!sb_rw && sb_adr == 8'h0C) begin
        if (sr_q.size() > 0) sb_dat_r = sr_q.pop_front();
        else                 sb_dat_r = 8'h18;
      end
      if (!sb_rw && sb_adr == 8'h0E && rx_q.size() > 0) sb_dat_r = rx_q.pop_front();
      obs_bus.push_back({sb_rw, sb_adr, sb_rw ? sb_dat_w : 8'h00});
      if (sb_rw && sb_adr == 8'h0D) txdr_cnt++;
      if (sb_rw && sb_adr == 8'h0F) csr_cnt++;
    end else begin
      sb_ack = 1'b0;
    end
    resp_prev = sb_stb;
  end

  // Stream and strobe-shape monitor.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) obs_rx.push_back(rx_data);
    if (tx_ready) tx_hi_cnt++;
    if (sb_stb) begin
      if (!mon_prev) begin
        if (have_fall && lo_run < min_gap) min_gap = lo_run;
        hi_run = 0;
        stb_ref = {sb_rw, sb_adr, sb_dat_w};
      end
      hi_run++;
      if ({sb_rw, sb_adr, sb_dat_w} !== stb_ref) unstable = 1'b1;
    end else begin
      if (mon_prev) begin
        have_fall = 1'b1;
        lo_run = 0;
        if (hi_run > max_hi) max_hi = hi_run;
      end
      lo_run++;
    end
    mon_prev = sb_stb;
  end

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (!busy && obs_bus.size() >= exp_bus.size()) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_frame(input logic [1:0] cs, input int n, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2, output bit ok);
    int t;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      tx_valid = 1'b1;
      tx_cs    = cs;
      tx_data  = (i == 0) ? b0 : (i == 1) ? b1 : b2;
      tx_last  = (i == n - 1);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!tx_ready && t < 400);
      if (!tx_ready) ok = 1'b0;
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  task automatic reset_window();
    min_gap = 999; max_hi = 0; unstable = 1'b0; have_fall = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    logic [16:0] e, o;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (sb_stb !== 1'b0)     begin n_fail++; $display("FAIL rst_stb: got %b required 0", sb_stb); end
    n_chk++; if (sb_rw !== 1'b0)      begin n_fail++; $display("FAIL rst_rw: got %b required 0", sb_rw); end
    n_chk++; if (sb_adr !== 8'h00)    begin n_fail++; $display("FAIL rst_adr: got %h required 00", sb_adr); end
    n_chk++; if (sb_dat_w !== 8'h00)  begin n_fail++; $display("FAIL rst_datw: got %h required 00", sb_dat_w); end
    n_chk++; if (tx_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_txrdy: got %b required 0", tx_ready); end
    n_chk++; if (rx_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_rxvld: got %b required 0", rx_valid); end
    n_chk++; if (rx_data !== 8'h00)   begin n_fail++; $display("FAIL rst_rxdata: got %h required 00", rx_data); end
    n_chk++; if (busy !== 1'b1)       begin n_fail++; $display("FAIL rst_busy: got %b required 1", busy); end
    n_chk++; if (err !== 1'b0)        begin n_fail++; $display("FAIL rst_err: got %b required 0", err); end
    exp_bus.push_back(wr(8'h08, 8'h00));
    exp_bus.push_back(wr(8'h09, 8'h80));
    exp_bus.push_back(wr(8'h0A, 8'hC0));
    exp_bus.push_back(wr(8'h0B, 8'h05));
    @(posedge clk); #1 rst_n = 1'b1;
    wait_done(200, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL cfg_done: busy=%b after budget, required 0", busy); end
    while (exp_bus.size() > 0) begin
      e = exp_bus.pop_front();
      o = (obs_bus.size() > 0) ? obs_bus.pop_front() : 17'h1ffff;
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL cfg_seq: got %h required %h", o, e); end
    end
    n_chk++; if (obs_bus.size() != 0) begin n_fail++; $display("FAIL cfg_extra: got %0d extra accesses required 0", obs_bus.size()); end
    obs_bus.delete();
  endtask

  task automatic test_one_byte();
    bit ok;
    logic [16:0] e, o;
    logic [7:0] er, orx;
    sr_q = '{8'h10, 8'h08, 8'h00};
    rx_q = '{8'h3C};
    exp_bus = '{wr(8'h0F, 8'h04), rd(8'h0C), wr(8'h0D, 8'hA5), rd(8'h0C), rd(8'h0E),
                rd(8'h0C), wr(8'h0F, 8'h00)};
    exp_rx.push_back(8'h3C);
    send_frame(2'd2, 1, 8'hA5, 8'h00, 8'h00, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL one_tx: tx_ready never seen, required handshake"); end
    wait_done(300, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL one_done: busy=%b obs=%0d, required idle", busy, obs_bus.size()); end
    while (exp_bus.size() > 0) begin
      e = exp_bus.pop_front();
      o = (obs_bus.size() > 0) ? obs_bus.pop_front() : 17'h1ffff;
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL one_seq: got %h required %h", o, e); end
    end
    while (exp_rx.size() > 0) begin
      er  = exp_rx.pop_front();
      orx = (obs_rx.size() > 0) ? obs_rx.pop_front() : 8'hxx;
      n_chk++; if (orx !== er) begin n_fail++; $display("FAIL one_rx: got %h required %h", orx, er); end
    end
    obs_bus.delete(); obs_rx.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int csr0, tx0, txdr0, t;
    logic [16:0] e, o;
    logic [7:0] er, orx;
    rx_q = '{8'hC1, 8'hC2, 8'hC3};
    exp_bus = '{wr(8'h0F, 8'h02),
                rd(8'h0C), wr(8'h0D, 8'h11), rd(8'h0C), rd(8'h0E),
                rd(8'h0C), wr(8'h0D, 8'h22), rd(8'h0C), rd(8'h0E),
                rd(8'h0C), wr(8'h0D, 8'h33), rd(8'h0C), rd(8'h0E),
                rd(8'h0C), wr(8'h0F, 8'h00)};
    exp_rx = '{8'hC1, 8'hC2, 8'hC3};
    csr0 = csr_cnt; tx0 = tx_hi_cnt; txdr0 = txdr_cnt;
    fork
      send_frame(2'd1, 3, 8'h11, 8'h22, 8'h33, ok);
      begin
        for (t = 0; t < 300 && obs_rx.size() < 1; t++) @(negedge clk);
        @(posedge clk); #1 rx_ready = 1'b0;
        for (t = 0; t < 300 && !rx_valid; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        n_chk++; if (txdr_cnt - txdr0 != 2) begin n_fail++; $display("FAIL b2b_hold_txdr: got %0d writes required 2", txdr_cnt - txdr0); end
        n_chk++; if (tx_hi_cnt - tx0 != 2) begin n_fail++; $display("FAIL b2b_hold_txrdy: got %0d required 2", tx_hi_cnt - tx0); end
        n_chk++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_hold_rxvld: got %b required 1", rx_valid); end
        @(posedge clk); #1 rx_ready = 1'b1;
      end
    join
    n_chk++; if (!ok) begin n_fail++; $display("FAIL b2b_tx: handshake missing, required 3 bytes"); end
    wait_done(400, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL b2b_done: busy=%b, required idle", busy); end
    n_chk++; if (csr_cnt - csr0 != 2) begin n_fail++; $display("FAIL b2b_csr: got %0d writes required 2", csr_cnt - csr0); end
    while (exp_bus.size() > 0) begin
      e = exp_bus.pop_front();
      o = (obs_bus.size() > 0) ? obs_bus.pop_front() : 17'h1ffff;
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL b2b_seq: got %h required %h", o, e); end
    end
    while (exp_rx.size() > 0) begin
      er  = exp_rx.pop_front();
      orx = (obs_rx.size() > 0) ? obs_rx.pop_front() : 8'hxx;
      n_chk++; if (orx !== er) begin n_fail++; $display("FAIL b2b_rx: got %h required %h", orx, er); end
    end
    obs_bus.delete(); obs_rx.delete();
  endtask

  task automatic test_trdy_wait();
    bit ok;
    int tx0;
    logic [16:0] e, o;
    sr_q = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h08, 8'h00};
    rx_q = '{8'h5E};
    exp_bus = '{wr(8'h0F, 8'h08), rd(8'h0C), rd(8'h0C), rd(8'h0C), rd(8'h0C),
                wr(8'h0D, 8'h69), rd(8'h0C), rd(8'h0E), rd(8'h0C), wr(8'h0F, 8'h00)};
    tx0 = tx_hi_cnt;
    reset_window();
    send_frame(2'd3, 1, 8'h69, 8'h00, 8'h00, ok);
    wait_done(300, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL trdy_done: busy=%b, required idle", busy); end
    n_chk++; if (tx_hi_cnt - tx0 != 1) begin n_fail++; $display("FAIL trdy_pulse: got %0d cycles required 1", tx_hi_cnt - tx0); end
    n_chk++; if (min_gap != 1) begin n_fail++; $display("FAIL trdy_gap: got %0d required 1", min_gap); end
    n_chk++; if (max_hi != 2) begin n_fail++; $display("FAIL trdy_stblen: got %0d required 2", max_hi); end
    n_chk++; if (unstable) begin n_fail++; $display("FAIL trdy_stable: got changing bus fields required stable"); end
    while (exp_bus.size() > 0) begin
      e = exp_bus.pop_front();
      o = (obs_bus.size() > 0) ? obs_bus.pop_front() : 17'h1ffff;
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL trdy_seq: got %h required %h", o, e); end
    end
    obs_bus.delete(); obs_rx.delete();
  endtask

  task automatic test_timeout();
    bit ok;
    int len, t;
    logic [16:0] e, o;
    logic [7:0] orx;
    rx_q = '{8'h96};
    exp_bus = '{wr(8'h0F, 8'h01), rd(8'h0C), wr(8'h0D, 8'h5A), rd(8'h0C), rd(8'h0E),
                rd(8'h0C), wr(8'h0F, 8'h00)};
    noack = 1'b1;
    len = 0;
    fork
      send_frame(2'd0, 1, 8'h5A, 8'h00, 8'h00, ok);
      begin
        for (t = 0; t < 50 && !sb_stb; t++) @(negedge clk);
        while (sb_stb && len < 100) begin
          len++;
          @(negedge clk);
        end
        noack = 1'b0;
        n_chk++; if (len != 16) begin n_fail++; $display("FAIL tmo_len: got %0d cycles required 16", len); end
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b required 1", err); end
      end
    join
    wait_done(300, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL tmo_retry: busy=%b, required idle", busy); end
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b required 1", err); end
    while (exp_bus.size() > 0) begin
      e = exp_bus.pop_front();
      o = (obs_bus.size() > 0) ? obs_bus.pop_front() : 17'h1ffff;
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL tmo_seq: got %h required %h", o, e); end
    end
    orx = (obs_rx.size() > 0) ? obs_rx.pop_front() : 8'hxx;
    n_chk++; if (orx !== 8'h96) begin n_fail++; $display("FAIL tmo_rx: got %h required 96", orx); end
    obs_bus.delete(); obs_rx.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t;
    logic [16:0] e, o;
    exp_bus = '{wr(8'h0F, 8'h01), rd(8'h0C),
                wr(8'h08, 8'h00), wr(8'h09, 8'h80), wr(8'h0A, 8'hC0), wr(8'h0B, 8'h05)};
    tx_valid = 1'b1; tx_data = 8'h77; tx_last = 1'b1; tx_cs = 2'd0;
    for (t = 0; t < 200 && !(sb_stb && sb_adr == 8'h0D); t++) @(negedge clk);
    n_chk++; if (!(sb_stb && sb_adr == 8'h0D)) begin n_fail++; $display("FAIL rmid_txdr: adr=%h stb=%b, required TXDR strobe", sb_adr, sb_stb); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (sb_stb !== 1'b0) begin n_fail++; $display("FAIL rmid_stb: got %b required 0", sb_stb); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rmid_err: got %b required 0", err); end
    tx_valid = 1'b0; tx_last = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    wait_done(200, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rmid_cfg: busy=%b, required idle", busy); end
    while (exp_bus.size() > 0) begin
      e = exp_bus.pop_front();
      o = (obs_bus.size() > 0) ? obs_bus.pop_front() : 17'h1ffff;
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL rmid_seq: got %h required %h", o, e); end
    end
    n_chk++; if (obs_bus.size() != 0) begin n_fail++; $display("FAIL rmid_extra: got %0d extra accesses required 0", obs_bus.size()); end
  endtask

  initial begin
    test_reset();
    test_one_byte();
    test_back_to_back();
    test_trdy_wait();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
